// File: rtl/puf_cha_sched.sv
// Challenge scheduler for a read-write-collision PUF: sweeps NUM_CHA challenges,
// collects REPEAT generator samples per challenge and emits a majority response bit.
module puf_cha_sched #(
    parameter int NUM_CHA = 16,
    parameter int REPEAT  = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [9:0]  base_addr,
    input  logic [31:0] seed_data,
    output logic        gen_enable,
    output logic [9:0]  cha_addr,
    output logic [31:0] cha_data,
    input  logic        available,
    input  logic        rsp_write,
    input  logic        rsp_clean,
    output logic        rsp_valid,
    output logic        rsp_bit,
    output logic [9:0]  rsp_index,
    output logic        busy,
    output logic        done,
    output logic        timeout_err
);

    // Timer is at least 10 bits but grows if TIMEOUT needs more.
    localparam int TW = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ARM, S_WAIT, S_TALLY, S_NEXT, S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [9:0]     base_q, base_d;
    logic [31:0]    seed_q, seed_d;
    logic [9:0]     index_q, index_d;
    logic [7:0]     w_cnt_q, w_cnt_d;
    logic [7:0]     c_cnt_q, c_cnt_d;
    logic [7:0]     samp_cnt_q, samp_cnt_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           gen_enable_q, gen_enable_d;
    logic [9:0]     cha_addr_q, cha_addr_d;
    logic [31:0]    cha_data_q, cha_data_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           rsp_bit_q, rsp_bit_d;
    logic [9:0]     rsp_index_q, rsp_index_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           timeout_err_q, timeout_err_d;
    logic           finish;
    logic           tmo;

    function automatic logic [31:0] rotl(input logic [31:0] v, input logic [4:0] n);
        logic [63:0] dbl;
        dbl = {v, v} << n;
        return dbl[63:32];
    endfunction

    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        seed_d        = seed_q;
        index_d       = index_q;
        w_cnt_d       = w_cnt_q;
        c_cnt_d       = c_cnt_q;
        samp_cnt_d    = samp_cnt_q;
        timer_d       = timer_q;
        gen_enable_d  = gen_enable_q;
        cha_addr_d    = cha_addr_q;
        cha_data_d    = cha_data_q;
        rsp_valid_d   = 1'b0;
        rsp_bit_d     = rsp_bit_q;
        rsp_index_d   = rsp_index_q;
        done_d        = 1'b0;
        timeout_err_d = timeout_err_q;
        finish        = 1'b0;
        tmo           = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d        = base_addr;
                    seed_d        = seed_data;
                    index_d       = '0;
                    timeout_err_d = 1'b0;
                    rsp_bit_d     = 1'b0;
                    rsp_index_d   = '0;
                    state_d       = S_LOAD;
                end
            end
            S_LOAD: begin
                cha_addr_d = base_q + index_q;
                cha_data_d = rotl(seed_q, index_q[4:0]);
                w_cnt_d    = '0;
                c_cnt_d    = '0;
                samp_cnt_d = '0;
                timer_d    = '0;
                state_d    = S_ARM;
            end
            S_ARM: begin
                if (available) begin
                    gen_enable_d = 1'b1;
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                // A simultaneous write+clean is a single write-won sample.
                if (rsp_write || rsp_clean) begin
                    samp_cnt_d = samp_cnt_q + 8'd1;
                    timer_d    = '0;
                    if (rsp_write) w_cnt_d = w_cnt_q + 8'd1;
                    else           c_cnt_d = c_cnt_q + 8'd1;
                    finish = (samp_cnt_d == 8'(REPEAT));
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    timer_d       = TW'(TIMEOUT);
                    timeout_err_d = 1'b1;
                    tmo           = 1'b1;
                    finish        = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
                if (finish) begin
                    gen_enable_d = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_bit_d    = !tmo && ({1'b0, w_cnt_d, 1'b0} > 10'(REPEAT));
                    rsp_index_d  = index_q;
                    state_d      = S_TALLY;
                end
            end
            S_TALLY: state_d = S_NEXT;
            S_NEXT: begin
                if (index_q == 10'(NUM_CHA - 1)) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    index_d = index_q + 10'd1;
                    state_d = S_LOAD;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            base_q        <= '0;
            seed_q        <= '0;
            index_q       <= '0;
            w_cnt_q       <= '0;
            c_cnt_q       <= '0;
            samp_cnt_q    <= '0;
            timer_q       <= '0;
            gen_enable_q  <= 1'b0;
            cha_addr_q    <= '0;
            cha_data_q    <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_bit_q     <= 1'b0;
            rsp_index_q   <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            seed_q        <= seed_d;
            index_q       <= index_d;
            w_cnt_q       <= w_cnt_d;
            c_cnt_q       <= c_cnt_d;
            samp_cnt_q    <= samp_cnt_d;
            timer_q       <= timer_d;
            gen_enable_q  <= gen_enable_d;
            cha_addr_q    <= cha_addr_d;
            cha_data_q    <= cha_data_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_bit_q     <= rsp_bit_d;
            rsp_index_q   <= rsp_index_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign gen_enable  = gen_enable_q;
    assign cha_addr    = cha_addr_q;
    assign cha_data    = cha_data_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_bit     = rsp_bit_q;
    assign rsp_index   = rsp_index_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = timeout_err_q;

endmodule
